// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-slot vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RELOAD,
    S_TRANSACT,
    S_VENDING
  } vend_state_e;

  localparam int COST_W    = 3;
  localparam int DIGIT_MAX = 9;
  localparam int SALES_W   = 16;

  localparam logic [3:0] DIGIT_MAX_V = 4'(DIGIT_MAX);
  localparam logic [7:0] COST_MAX_V  = 8'((1 << COST_W) - 1);

endpackage

// File: rtl/vend_key_capture.sv
// Two-digit item code capture with an inactivity timer shared by the key and
// payment phases of a transaction.
module vend_key_capture
  import vend_pkg::*;
#(
  parameter int KEY_TIMEOUT = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start_i,
  input  logic       keep_i,
  input  logic       keyPress_i,
  input  logic [3:0] itemCode_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       selDone_o,
  output logic       timerZero_o
);

  localparam int TMR_W = $clog2(KEY_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(KEY_TIMEOUT);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic [1:0]       keyCount_q, keyCount_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer_q    <= '0;
      tens_q     <= '0;
      units_q    <= '0;
      keyCount_q <= '0;
    end else begin
      timer_q    <= timer_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      keyCount_q <= keyCount_d;
    end
  end

  // Presses after the second digit, or after expiry, leave both digits and timer alone.
  always_comb begin
    timer_d    = timer_q;
    tens_d     = tens_q;
    units_d    = units_q;
    keyCount_d = keyCount_q;
    if (start_i) begin
      timer_d    = TMR_LOAD;
      tens_d     = '0;
      units_d    = '0;
      keyCount_d = '0;
    end else if (!keep_i) begin
      timer_d    = '0;
      tens_d     = '0;
      units_d    = '0;
      keyCount_d = '0;
    end else if (keyPress_i && (keyCount_q != 2'd2) && (timer_q != '0)) begin
      timer_d    = TMR_LOAD;
      keyCount_d = keyCount_q + 2'd1;
      if (keyCount_q == 2'd0) begin
        tens_d = itemCode_i;
      end else begin
        units_d = itemCode_i;
      end
    end else if (timer_q != '0) begin
      timer_d = timer_q - TMR_W'(1);
    end
  end

  assign tens_o      = tens_q;
  assign units_o     = units_q;
  assign selDone_o   = (keyCount_q == 2'd2);
  assign timerZero_o = (timer_q == '0);

endmodule

// File: rtl/multi_vend_ctrl.sv
// Multi-slot vending controller: state machine, stock array, pricing and sales.
// Optional sales counter enabled by defining VEND_SALES_CNT_EN.
module multi_vend_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS     = 20,
  parameter int STOCK_W       = 4,
  parameter int STOCK_MAX     = 10,
  parameter int KEY_TIMEOUT   = 5,
  parameter int VEND_TIMEOUT  = 4,
  parameter int PREMIUM_ITEMS = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               RELOAD,
  input  logic               CARD_IN,
  input  logic [3:0]         ITEM_CODE,
  input  logic               KEY_PRESS,
  input  logic               VALID_TRAN,
  input  logic               DOOR_OPEN,
  output logic               VEND,
  output logic               INVALID_SEL,
  output logic               FAILED_TRAN,
  output logic [COST_W-1:0]  COST,
  output logic [STOCK_W-1:0] STOCK_OUT,
  output logic [SALES_W-1:0] SALES
);

  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int VT_W  = $clog2(VEND_TIMEOUT + 1);
  localparam logic [7:0]         NUM_ITEMS_V    = 8'(NUM_ITEMS);
  localparam logic [7:0]         PREMIUM_BASE_V = 8'(NUM_ITEMS - PREMIUM_ITEMS);
  localparam logic [STOCK_W-1:0] STOCK_FULL     = STOCK_W'(STOCK_MAX);
  localparam logic [VT_W-1:0]    VT_LIMIT       = VT_W'(VEND_TIMEOUT);

  vend_state_e state_q, state_d;

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic               doorSeen_q, doorSeen_d;
  logic [VT_W-1:0]    vendCnt_q, vendCnt_d;

  logic [3:0]         tens, units;
  logic               selDone, timerZero;
  logic               keyStart, keyKeep;
  logic [7:0]         item;
  logic [IDX_W-1:0]   itemIdx;
  logic               itemLegal;
  logic [STOCK_W-1:0] selStock;
  logic               selValid;
  logic [7:0]         costRaw;
  logic [COST_W-1:0]  selCost;
  logic               vendGo;

  vend_key_capture #(
    .KEY_TIMEOUT(KEY_TIMEOUT)
  ) u_keys (
    .CLK        (CLK),
    .RESET      (RESET),
    .start_i    (keyStart),
    .keep_i     (keyKeep),
    .keyPress_i (KEY_PRESS),
    .itemCode_i (ITEM_CODE),
    .tens_o     (tens),
    .units_o    (units),
    .selDone_o  (selDone),
    .timerZero_o(timerZero)
  );

  assign keyStart = (state_q == S_IDLE) && (state_d == S_TRANSACT);
  assign keyKeep  = (state_d == S_TRANSACT) || (state_d == S_VENDING);

  // Out-of-range items never index the stock array; they read as empty instead.
  assign item      = 8'(tens) * 8'd10 + 8'(units);
  assign itemIdx   = item[IDX_W-1:0];
  assign itemLegal = (tens <= DIGIT_MAX_V) && (units <= DIGIT_MAX_V) && (item < NUM_ITEMS_V);
  assign selStock  = itemLegal ? stock_q[itemIdx] : '0;
  assign selValid  = selDone && itemLegal && (selStock != '0);
  assign costRaw   = {2'b00, item[7:2]} + 8'd1 + {7'd0, (item >= PREMIUM_BASE_V)};
  assign selCost   = (costRaw > COST_MAX_V) ? COST_MAX_V[COST_W-1:0] : costRaw[COST_W-1:0];
  assign vendGo    = (state_q == S_TRANSACT) && selValid && VALID_TRAN && !timerZero;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      doorSeen_q <= 1'b0;
      vendCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      doorSeen_q <= doorSeen_d;
      vendCnt_q  <= vendCnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (RELOAD) begin
          state_d = S_RELOAD;
        end else if (CARD_IN) begin
          state_d = S_TRANSACT;
        end
      end
      S_RELOAD: begin
        if (!RELOAD) begin
          state_d = S_IDLE;
        end
      end
      S_TRANSACT: begin
        if (!selDone) begin
          if (timerZero) begin
            state_d = S_IDLE;
          end
        end else if (!selValid) begin
          state_d = S_IDLE;
        end else if (vendGo) begin
          state_d = S_VENDING;
        end else if (timerZero) begin
          state_d = S_IDLE;
        end
      end
      S_VENDING: begin
        if (doorSeen_q && !DOOR_OPEN) begin
          state_d = S_IDLE;
        end else if (!doorSeen_q && !DOOR_OPEN && (vendCnt_q >= VT_LIMIT)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // vendCnt_q counts VEND-high cycles so an unopened door releases after VEND_TIMEOUT.
  always_comb begin
    doorSeen_d = 1'b0;
    vendCnt_d  = '0;
    if (vendGo) begin
      vendCnt_d = VT_W'(1);
    end else if (state_q == S_VENDING) begin
      doorSeen_d = doorSeen_q || DOOR_OPEN;
      vendCnt_d  = (vendCnt_q < VT_LIMIT) ? vendCnt_q + VT_W'(1) : vendCnt_q;
    end
  end

  always_comb begin
    VEND        = (state_q == S_VENDING);
    INVALID_SEL = 1'b0;
    FAILED_TRAN = 1'b0;
    COST        = '0;
    STOCK_OUT   = '0;
    if (state_q == S_TRANSACT) begin
      INVALID_SEL = selDone ? !selValid : timerZero;
      FAILED_TRAN = selValid && timerZero;
    end
    if (((state_q == S_TRANSACT) && selValid) || (state_q == S_VENDING)) begin
      COST      = selCost;
      STOCK_OUT = selStock;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (RESET) begin
        stock_q[i] <= '0;
      end else if (state_q == S_RELOAD) begin
        stock_q[i] <= STOCK_FULL;
      end else if (vendGo && (itemIdx == IDX_W'(i)) && (stock_q[i] != '0)) begin
        stock_q[i] <= stock_q[i] - STOCK_W'(1);
      end
    end
  end

`ifdef VEND_SALES_CNT_EN
  logic [SALES_W-1:0] sales_q, sales_d;

  always_comb begin
    sales_d = vendGo ? sales_q + SALES_W'(1) : sales_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sales_q <= '0;
    end else begin
      sales_q <= sales_d;
    end
  end

  assign SALES = sales_q;
`else
  assign SALES = '0;
`endif

endmodule

// File: tb/tb_multi_vend_ctrl.sv
// Directed self-checking bench for multi_vend_ctrl with default parameters.
module tb_multi_vend_ctrl;

  logic        clk = 1'b0;
  logic        reset, reload, cardIn, keyPress, validTran, doorOpen;
  logic [3:0]  itemCode;
  logic        vend, invalidSel, failedTran;
  logic [2:0]  cost;
  logic [3:0]  stockOut;
  logic [15:0] sales;

  int checkCount = 0;
  int errorCount = 0;
  int vendCount  = 0;

  always #5 clk = ~clk;

  multi_vend_ctrl dut (
    .CLK        (clk),
    .RESET      (reset),
    .RELOAD     (reload),
    .CARD_IN    (cardIn),
    .ITEM_CODE  (itemCode),
    .KEY_PRESS  (keyPress),
    .VALID_TRAN (validTran),
    .DOOR_OPEN  (doorOpen),
    .VEND       (vend),
    .INVALID_SEL(invalidSel),
    .FAILED_TRAN(failedTran),
    .COST       (cost),
    .STOCK_OUT  (stockOut),
    .SALES      (sales)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs change just after a falling edge, so each call spans exactly one rising edge.
  task automatic applyStimulus(input logic rl, input logic cd, input logic kp,
                               input logic [3:0] code, input logic vt, input logic dr);
    reload    = rl;
    cardIn    = cd;
    keyPress  = kp;
    itemCode  = code;
    validTran = vt;
    doorOpen  = dr;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic doReload();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    idleCycle();
  endtask

  task automatic selectItem(input logic [3:0] tensDigit, input logic [3:0] unitsDigit);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, tensDigit, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, unitsDigit, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] salesExp(input int n);
`ifdef VEND_SALES_CNT_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    reset = 1'b1;
    idleCycle();
    idleCycle();
    reset = 1'b0;
    checkOutput("rst_vend", 32'(vend), 0);
    checkOutput("rst_inv", 32'(invalidSel), 0);
    checkOutput("rst_fail", 32'(failedTran), 0);
    checkOutput("rst_cost", 32'(cost), 0);
    checkOutput("rst_stock", 32'(stockOut), 0);
    checkOutput("rst_sales", 32'(sales), 0);

    // Basic purchase of item 05 with a door open/close cycle
    doReload();
    selectItem(4'd0, 4'd5);
    checkOutput("a_cost", 32'(cost), 2);
    checkOutput("a_stock", 32'(stockOut), 10);
    checkOutput("a_inv", 32'(invalidSel), 0);
    checkOutput("a_vend_pre", 32'(vend), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    vendCount++;
    checkOutput("a_vend", 32'(vend), 1);
    checkOutput("a_stock_after", 32'(stockOut), 9);
    checkOutput("a_cost_hold", 32'(cost), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("a_vend_door", 32'(vend), 1);
    idleCycle();
    checkOutput("a_vend_close", 32'(vend), 0);
    checkOutput("a_cost_close", 32'(cost), 0);
    checkOutput("a_sales", 32'(sales), salesExp(vendCount));

    // Empty machine: item 03 has no stock
    reset = 1'b1;
    idleCycle();
    reset = 1'b0;
    vendCount = 0;
    selectItem(4'd0, 4'd3);
    checkOutput("b_inv", 32'(invalidSel), 1);
    checkOutput("b_fail", 32'(failedTran), 0);
    checkOutput("b_cost", 32'(cost), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("b_inv_once", 32'(invalidSel), 0);
    checkOutput("b_cost_idle", 32'(cost), 0);
    checkOutput("b_no_vend", 32'(vend), 0);

    // Out-of-range item, illegal digit, then premium item 19
    doReload();
    selectItem(4'd2, 4'd5);
    checkOutput("c_inv_range", 32'(invalidSel), 1);
    idleCycle();
    checkOutput("c_inv_once", 32'(invalidSel), 0);
    selectItem(4'd0, 4'd12);
    checkOutput("c_inv_digit", 32'(invalidSel), 1);
    idleCycle();
    selectItem(4'd1, 4'd9);
    checkOutput("c_cost19", 32'(cost), 6);
    checkOutput("c_stock19", 32'(stockOut), 10);
    checkOutput("c_inv19", 32'(invalidSel), 0);

    // Payment withheld: FAILED_TRAN on the 5th edge after the second press
    for (int k = 1; k <= 6; k++) begin
      idleCycle();
      checkOutput($sformatf("d_fail_k%0d", k), 32'(failedTran), (k == 5) ? 1 : 0);
      checkOutput($sformatf("d_inv_k%0d", k), 32'(invalidSel), 0);
    end
    checkOutput("d_cost_idle", 32'(cost), 0);
    selectItem(4'd1, 4'd9);
    checkOutput("d_stock_kept", 32'(stockOut), 10);

    // Door never opens: VEND high for 4 cycles
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    vendCount++;
    checkOutput("e_vend", 32'(vend), 1);
    checkOutput("e_cost", 32'(cost), 6);
    for (int k = 1; k <= 4; k++) begin
      idleCycle();
      checkOutput($sformatf("e_vend_k%0d", k), 32'(vend), (k < 4) ? 1 : 0);
    end
    checkOutput("e_sales", 32'(sales), salesExp(vendCount));

    // Reset while vending item 18
    selectItem(4'd1, 4'd8);
    checkOutput("r_cost18", 32'(cost), 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("r_vend", 32'(vend), 1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    reset = 1'b0;
    vendCount = 0;
    checkOutput("r_vend_rst", 32'(vend), 0);
    checkOutput("r_cost_rst", 32'(cost), 0);
    checkOutput("r_stockout_rst", 32'(stockOut), 0);
    checkOutput("r_sales_rst", 32'(sales), 0);
    idleCycle();
    selectItem(4'd1, 4'd9);
    checkOutput("r_stock_zero", 32'(invalidSel), 1);
    idleCycle();

    // Drain slot 0: ten good vends then an invalid eleventh
    doReload();
    for (int n = 0; n < 11; n++) begin
      selectItem(4'd0, 4'd0);
      if (n < 10) begin
        checkOutput($sformatf("f_cost_n%0d", n), 32'(cost), 1);
        checkOutput($sformatf("f_stock_n%0d", n), 32'(stockOut), 32'(10 - n));
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        vendCount++;
        checkOutput($sformatf("f_vend_n%0d", n), 32'(vend), 1);
        checkOutput($sformatf("f_left_n%0d", n), 32'(stockOut), 32'(9 - n));
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        idleCycle();
        checkOutput($sformatf("f_done_n%0d", n), 32'(vend), 0);
      end else begin
        checkOutput("f_inv_11", 32'(invalidSel), 1);
        checkOutput("f_stock_11", 32'(stockOut), 0);
        checkOutput("f_cost_11", 32'(cost), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("f_no_vend_11", 32'(vend), 0);
      end
    end
    checkOutput("f_sales", 32'(sales), salesExp(vendCount));

    // Key timeout after only the first digit
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      idleCycle();
      checkOutput($sformatf("g_inv_k%0d", k), 32'(invalidSel), (k == 5) ? 1 : 0);
      checkOutput($sformatf("g_fail_k%0d", k), 32'(failedTran), 0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
